// File: rtl/ijvm_pkg.sv
// Shared IJVM datapath definitions: control-field bit positions, C-bus
// destination indices and the ALU/C-bus driver state encoding.
package ijvm_pkg;

  // alu_ctrl = {F0, F1, ENA, ENB, INVA, INC}
  localparam int unsigned AluF0   = 5;
  localparam int unsigned AluF1   = 4;
  localparam int unsigned AluEna  = 3;
  localparam int unsigned AluEnb  = 2;
  localparam int unsigned AluInva = 1;
  localparam int unsigned AluInc  = 0;

  // shift_ctrl = {SLL8, SRA1}
  localparam int unsigned ShSll8 = 1;
  localparam int unsigned ShSra1 = 0;

  typedef enum int unsigned {
    CIdxH   = 0,
    CIdxOpc = 1,
    CIdxTos = 2,
    CIdxCpp = 3,
    CIdxLv  = 4,
    CIdxSp  = 5,
    CIdxPc  = 6,
    CIdxMdr = 7,
    CIdxMar = 8
  } c_idx_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StExec  = 2'd1,
    StWrite = 2'd2
  } state_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational ALU plus shifter. Flags come from the ALU output, ahead of
// the shifter.
module alu_shifter
  import ijvm_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] h_val,
  input  logic [WORD_WIDTH-1:0] b_val,
  input  logic [5:0]            alu_ctrl,
  input  logic [1:0]            shift_ctrl,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  n,
  output logic                  z
);

  logic [WORD_WIDTH-1:0] a_op;
  logic [WORD_WIDTH-1:0] b_op;
  logic [WORD_WIDTH-1:0] alu_out;

  always_comb begin
    a_op = alu_ctrl[AluEna] ? h_val : '0;
    if (alu_ctrl[AluInva]) begin
      a_op = ~a_op;
    end
    b_op = alu_ctrl[AluEnb] ? b_val : '0;

    unique case ({alu_ctrl[AluF0], alu_ctrl[AluF1]})
      2'b00:   alu_out = a_op & b_op;
      2'b01:   alu_out = a_op | b_op;
      2'b10:   alu_out = ~b_op;
      default: alu_out = a_op + b_op + WORD_WIDTH'(alu_ctrl[AluInc]);
    endcase

    // SLL8 wins when both shift bits are set; narrow words shift out entirely.
    if (shift_ctrl[ShSll8]) begin
      result = (WORD_WIDTH > 8) ? (alu_out << 8) : '0;
    end else if (shift_ctrl[ShSra1]) begin
      result = {alu_out[WORD_WIDTH-1], alu_out[WORD_WIDTH-1:1]};
    end else begin
      result = alu_out;
    end

    n = alu_out[WORD_WIDTH-1];
    z = (alu_out == '0);
  end

endmodule

// File: rtl/alu_c_driver.sv
// Execution unit: latches B-bus operands, runs one ALU/shift operation against
// H and drives the result onto the C bus with one-cycle destination strobes.
module alu_c_driver
  import ijvm_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned C_SEL_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WORD_WIDTH-1:0]  b_bus,
  input  logic [5:0]             alu_ctrl,
  input  logic [1:0]             shift_ctrl,
  input  logic [C_SEL_WIDTH-1:0] c_select,
  output logic [WORD_WIDTH-1:0]  c_bus,
  output logic [C_SEL_WIDTH-1:0] c_write_enable,
  output logic                   n_flag,
  output logic                   z_flag,
  output logic                   busy,
  output logic                   done
);

  state_e state_q, state_d;

  logic [WORD_WIDTH-1:0]  b_q;
  logic [5:0]             alu_ctrl_q;
  logic [1:0]             shift_ctrl_q;
  logic [C_SEL_WIDTH-1:0] sel_q;
  logic [WORD_WIDTH-1:0]  h_q;
  logic [WORD_WIDTH-1:0]  result_q;
  logic [C_SEL_WIDTH-1:0] we_q;
  logic                   drive_q;
  logic                   n_q;
  logic                   z_q;

  logic [WORD_WIDTH-1:0]  alu_res;
  logic                   alu_n;
  logic                   alu_z;

  alu_shifter #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_alu_shifter (
    .h_val     (h_q),
    .b_val     (b_q),
    .alu_ctrl  (alu_ctrl_q),
    .shift_ctrl(shift_ctrl_q),
    .result    (alu_res),
    .n         (alu_n),
    .z         (alu_z)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      b_q          <= '0;
      alu_ctrl_q   <= '0;
      shift_ctrl_q <= '0;
      sel_q        <= '0;
      h_q          <= '0;
      result_q     <= '0;
      we_q         <= '0;
      drive_q      <= 1'b0;
      n_q          <= 1'b0;
      z_q          <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            b_q          <= b_bus;
            alu_ctrl_q   <= alu_ctrl;
            shift_ctrl_q <= shift_ctrl;
            sel_q        <= c_select;
          end
        end
        StExec: begin
          result_q <= alu_res;
          n_q      <= alu_n;
          z_q      <= alu_z;
          we_q     <= sel_q;
          drive_q  <= 1'b1;
        end
        StWrite: begin
          // H is the only C-bus destination that lives inside this block.
          if (we_q[CIdxH]) h_q <= result_q;
          we_q    <= '0;
          drive_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign c_bus          = drive_q ? result_q : {WORD_WIDTH{1'bz}};
  assign c_write_enable = we_q;
  assign n_flag         = n_q;
  assign z_flag         = z_q;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StWrite);

endmodule

// File: tb/tb_alu_c_driver.sv
// Scoreboard bench for alu_c_driver: stimulus pushes expected C-bus writes,
// a negedge monitor pops and compares whenever done is high.
module tb_alu_c_driver;

  typedef struct {
    logic [7:0] c;
    logic [8:0] we;
    logic       n;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] b_bus;
  logic [5:0] alu_ctrl;
  logic [1:0] shift_ctrl;
  logic [8:0] c_select;
  wire  [7:0] c_bus;
  logic [8:0] c_write_enable;
  logic       n_flag, z_flag, busy, done;

  logic        start16;
  logic [15:0] b16;
  logic [5:0]  ctrl16;
  logic [1:0]  sh16;
  logic [8:0]  sel16;
  wire  [15:0] c_bus16;
  logic [8:0]  we16;
  logic        n16, z16, busy16, done16;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  int   h_model = 0;

  always #5 clk = ~clk;

  alu_c_driver #(.WORD_WIDTH(8), .C_SEL_WIDTH(9)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .b_bus         (b_bus),
    .alu_ctrl      (alu_ctrl),
    .shift_ctrl    (shift_ctrl),
    .c_select      (c_select),
    .c_bus         (c_bus),
    .c_write_enable(c_write_enable),
    .n_flag        (n_flag),
    .z_flag        (z_flag),
    .busy          (busy),
    .done          (done)
  );

  alu_c_driver #(.WORD_WIDTH(16), .C_SEL_WIDTH(9)) dut16 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start16),
    .b_bus         (b16),
    .alu_ctrl      (ctrl16),
    .shift_ctrl    (sh16),
    .c_select      (sel16),
    .c_bus         (c_bus16),
    .c_write_enable(we16),
    .n_flag        (n16),
    .z_flag        (z16),
    .busy          (busy16),
    .done          (done16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: the 8-bit datapath expressed with plain integer arithmetic.
  function automatic exp_t model(input int h, input int b, input logic [5:0] c,
                                 input logic [1:0] sh, input logic [8:0] sel);
    exp_t e;
    int a, bb, alu, r;
    a  = c[3] ? h : 0;
    if (c[1]) a = 255 - a;
    bb = c[2] ? b : 0;
    case ({c[5], c[4]})
      2'b00:   alu = a & bb;
      2'b01:   alu = a | bb;
      2'b10:   alu = 255 - bb;
      default: alu = (a + bb + int'(c[0])) % 256;
    endcase
    if (sh[1])      r = 0;
    else if (sh[0]) r = alu / 2 + ((alu >= 128) ? 128 : 0);
    else            r = alu;
    e.c  = r[7:0];
    e.we = sel;
    e.n  = (alu >= 128);
    e.z  = (alu == 0);
    return e;
  endfunction

  // Caller sits at a negedge with the DUT idle; returns likewise, 3 cycles later.
  task automatic issue(input logic [7:0] b, input logic [5:0] c, input logic [1:0] sh,
                       input logic [8:0] sel, input bit junk);
    exp_t e;
    e = model(h_model, int'(b), c, sh, sel);
    exp_q.push_back(e);
    if (sel[0]) h_model = int'(e.c);
    b_bus = b; alu_ctrl = c; shift_ctrl = sh; c_select = sel; start = 1'b1;
    @(negedge clk);
    check("busy_exec", busy, 1);
    start = junk ? 1'($urandom) : 1'b0;
    b_bus = 8'($urandom); alu_ctrl = 6'($urandom);
    shift_ctrl = 2'($urandom); c_select = 9'($urandom);
    @(negedge clk);
    start = junk ? 1'($urandom) : 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: c_bus=%h we=%h, required no write", c_bus,
                   c_write_enable);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("c_bus", c_bus, e.c);
          check("c_we", c_write_enable, e.we);
          check("n_flag", n_flag, e.n);
          check("z_flag", z_flag, e.z);
        end
      end else begin
        check("we_idle", c_write_enable, 0);
      end
    end
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; start = 1'b0; b_bus = '0; alu_ctrl = '0; shift_ctrl = '0; c_select = '0;
    start16 = 1'b0; b16 = '0; ctrl16 = '0; sh16 = '0; sel16 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", c_write_enable, 0);
    check("rst_n_flag", n_flag, 0);
    check("rst_z_flag", z_flag, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    h_model = 0;

    // Directed: load H, add with wrap, subtract, SRA1, read H back.
    issue(8'h05, 6'b010100, 2'b00, 9'h001, 1'b0);
    issue(8'hFB, 6'b111100, 2'b00, 9'h008, 1'b0);
    issue(8'h03, 6'b111111, 2'b00, 9'h000, 1'b0);
    issue(8'h80, 6'b010100, 2'b01, 9'h000, 1'b0);
    issue(8'h00, 6'b011000, 2'b00, 9'h000, 1'b0);
    issue(8'h12, 6'b010100, 2'b11, 9'h002, 1'b0);

    // 16-bit SLL8 on the wide instance.
    b16 = 16'h0012; ctrl16 = 6'b010100; sh16 = 2'b10; sel16 = 9'h000; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    for (int i = 0; i < 8 && !done16; i++) @(negedge clk);
    if (!done16) begin
      n_cmp++;
      n_bad++;
      $display("FAIL w16_timeout: done16=%b, required 1 within 8 cycles", done16);
    end else begin
      check("w16_c_bus", c_bus16, 32'h1200);
      check("w16_we", we16, 0);
      check("w16_n", n16, 0);
    end
    @(negedge clk);

    // Reset while in WRITE: write completes on the bus but H must not update.
    b_bus = 8'h33; alu_ctrl = 6'b010100; shift_ctrl = 2'b00; c_select = 9'h001;
    e = model(h_model, 8'h33, 6'b010100, 2'b00, 9'h001);
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("wrst_busy", busy, 0);
    check("wrst_done", done, 0);
    check("wrst_we", c_write_enable, 0);
    check("wrst_n", n_flag, 0);
    check("wrst_z", z_flag, 0);
    rst_n = 1'b1;
    h_model = 0;
    issue(8'h00, 6'b011000, 2'b00, 9'h000, 1'b0);

    // Reset while in EXEC: no write may ever appear.
    b_bus = 8'h77; alu_ctrl = 6'b010100; c_select = 9'h1FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    h_model = 0;
    repeat (4) @(negedge clk);
    issue(8'h00, 6'b011000, 2'b00, 9'h000, 1'b0);

    // Random back-to-back ops with junk starts during EXEC and WRITE.
    for (int i = 0; i < 150; i++) begin
      logic [8:0] sel;
      case ($urandom % 4)
        0:       sel = 9'h000;
        1:       sel = 9'h001;
        default: sel = 9'($urandom);
      endcase
      issue(8'($urandom), 6'($urandom), 2'($urandom), sel, 1'b1);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
